// File: rtl/rep_collapse_ingest.sv
`default_nettype none
// ============================================================================
// Module   : rep_collapse_ingest
// Purpose  : Decoder-side repetition collapse. Takes the repetition-expanded
//            codeword as an in-order chunk stream. For every 128-bit inner block
//            it makes a per-bit majority vote over REP_COUNT copies and stores
//            one hard-decision block per outer symbol for address-based reads.
// Ports    : clk, rst_n (async, active-low)
//            start            - one-cycle pulse, (re)starts collection
//            in_valid/in_ready/data_in - chunk stream (byte b at data_in[8b+:8])
//            blk_rd_en/blk_rd_addr/blk_out - registered block read, latency 1
//            done             - level, all blocks collapsed
//            flip_cnt         - disagreement count (REP_FLIP_CNT_EN only)
// Options  : define REP_FLIP_CNT_EN to add the flip_cnt port and its logic.
// Revision : 1.0 - initial release
// ============================================================================
module rep_collapse_ingest #(
    parameter           PARAMETER_SET = "hqc192",
    parameter int       IN_WIDTH_BITS = 128,
    localparam int      N1_BYTES      = (PARAMETER_SET == "hqc128") ? 46 :
                                        (PARAMETER_SET == "hqc256") ? 90 : 56,
    localparam int      REP_COUNT     = (PARAMETER_SET == "hqc128") ? 3 : 5,
    localparam int      WPB           = 128 / IN_WIDTH_BITS,
    localparam int      CNT_W         = $clog2(REP_COUNT + 1),
    localparam int      ADDR_W        = $clog2(N1_BYTES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_WIDTH_BITS-1:0] data_in,
    input  logic                     blk_rd_en,
    input  logic [ADDR_W-1:0]        blk_rd_addr,
    output logic [127:0]             blk_out,
    output logic                     done
`ifdef REP_FLIP_CNT_EN
    ,
    output logic [15:0]              flip_cnt
`endif
);

    // Word index keeps at least one bit so the single-chunk-per-copy case stays legal.
    localparam int W_W = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int C_W = $clog2(REP_COUNT);

    localparam logic [1:0]       c_st_idle    = 2'd0;
    localparam logic [1:0]       c_st_collect = 2'd1;
    localparam logic [1:0]       c_st_done    = 2'd2;
    localparam logic [CNT_W-1:0] c_half       = CNT_W'(REP_COUNT / 2);
    localparam logic [CNT_W-1:0] c_rep        = CNT_W'(REP_COUNT);

    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic [W_W-1:0]          r_word;
    logic [C_W-1:0]          r_copy;
    logic [ADDR_W-1:0]       r_blk;
    logic [127:0][CNT_W-1:0] r_cnt;
    logic [127:0][CNT_W-1:0] w_cnt_next;
    logic [127:0]            w_vote;
    logic [127:0]            r_mem [N1_BYTES];
    logic [127:0]            r_blk_out;

    logic w_acc;
    logic w_last_word;
    logic w_last_copy;
    logic w_last_blk;
    logic w_fin;

    assign in_ready    = (r_state == c_st_collect);
    assign done        = (r_state == c_st_done);
    assign blk_out     = r_blk_out;

    // start has priority: a chunk presented alongside it is dropped.
    assign w_acc       = in_valid && in_ready && !start;
    assign w_last_word = (r_word == W_W'(WPB - 1));
    assign w_last_copy = (r_copy == C_W'(REP_COUNT - 1));
    assign w_last_blk  = (r_blk == ADDR_W'(N1_BYTES - 1));
    assign w_fin       = w_acc && w_last_word && w_last_copy;

    // Counter update including the chunk being accepted, so the vote on the
    // final chunk of a block sees every copy.
    always_comb begin
        w_cnt_next = r_cnt;
        w_vote     = '0;
        for (int k = 0; k < 128; k++) begin
            if (w_acc && (r_word == W_W'(k / IN_WIDTH_BITS)) && data_in[k % IN_WIDTH_BITS])
                w_cnt_next[k] = r_cnt[k] + CNT_W'(1);
            w_vote[k] = (w_cnt_next[k] > c_half);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:    if (start) w_state_next = c_st_collect;
            c_st_collect: begin
                if (start)                   w_state_next = c_st_collect;
                else if (w_fin && w_last_blk) w_state_next = c_st_done;
            end
            c_st_done:    if (start) w_state_next = c_st_collect;
            default:      w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_st_idle;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_copy <= '0;
            r_blk  <= '0;
            r_cnt  <= '0;
        end else if (start) begin
            r_word <= '0;
            r_copy <= '0;
            r_blk  <= '0;
            r_cnt  <= '0;
        end else if (w_acc) begin
            r_cnt <= w_fin ? '0 : w_cnt_next;
            if (w_last_word) begin
                r_word <= '0;
                if (w_last_copy) begin
                    r_copy <= '0;
                    r_blk  <= w_last_blk ? '0 : r_blk + ADDR_W'(1);
                end else begin
                    r_copy <= r_copy + C_W'(1);
                end
            end else begin
                r_word <= r_word + W_W'(1);
            end
        end
    end

    // Block store is not reset; contents only matter once done is high.
    always_ff @(posedge clk) begin
        if (w_fin) r_mem[r_blk] <= w_vote;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk_out <= '0;
        end else if (blk_rd_en) begin
            if ({1'b0, blk_rd_addr} < (ADDR_W + 1)'(N1_BYTES))
                r_blk_out <= r_mem[blk_rd_addr];
            else
                r_blk_out <= '0;
        end
    end

`ifdef REP_FLIP_CNT_EN
    logic [7:0]  w_pop;
    logic [16:0] w_flip_sum;
    logic [15:0] r_flip;

    // Bits whose copies disagree: count neither 0 nor REP_COUNT.
    always_comb begin
        w_pop = '0;
        for (int k = 0; k < 128; k++) begin
            if ((w_cnt_next[k] != '0) && (w_cnt_next[k] != c_rep))
                w_pop = w_pop + 8'd1;
        end
        w_flip_sum = {1'b0, r_flip} + {9'd0, w_pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_flip <= '0;
        else if (start) r_flip <= '0;
        else if (w_fin) r_flip <= w_flip_sum[16] ? 16'hFFFF : w_flip_sum[15:0];
    end

    assign flip_cnt = r_flip;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rep_collapse_ingest.sv
`default_nettype none
// ============================================================================
// Module   : tb_rep_collapse_ingest
// Purpose  : Self-checking bench for rep_collapse_ingest. Instance u_dut1 is
//            hqc192 with 128-bit chunks, u_dut2 is hqc128 with 64-bit chunks.
//            Expected blocks come from a majority-vote model over the copies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rep_collapse_ingest;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic         start1, in_valid1, rd_en1, in_ready1, done1;
    logic [127:0] data1, blk_out1;
    logic [5:0]   rd_addr1;
    logic         start2, in_valid2, rd_en2, in_ready2, done2;
    logic [63:0]  data2;
    logic [127:0] blk_out2;
    logic [5:0]   rd_addr2;
`ifdef REP_FLIP_CNT_EN
    logic [15:0]  flip1, flip2;
`endif

    rep_collapse_ingest #(.PARAMETER_SET("hqc192"), .IN_WIDTH_BITS(128)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid1),
        .in_ready(in_ready1), .data_in(data1), .blk_rd_en(rd_en1),
        .blk_rd_addr(rd_addr1), .blk_out(blk_out1), .done(done1)
`ifdef REP_FLIP_CNT_EN
        , .flip_cnt(flip1)
`endif
    );

    rep_collapse_ingest #(.PARAMETER_SET("hqc128"), .IN_WIDTH_BITS(64)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid2),
        .in_ready(in_ready2), .data_in(data2), .blk_rd_en(rd_en2),
        .blk_rd_addr(rd_addr2), .blk_out(blk_out2), .done(done2)
`ifdef REP_FLIP_CNT_EN
        , .flip_cnt(flip2)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [127:0] exp1 [56];
    logic [127:0] exp2 [46];
    int           eflip1, eflip2;
    logic [127:0] fm [5];
    logic [127:0] cp [5];

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] sparse128();
        return rand128() & rand128() & rand128() & rand128();
    endfunction

    // Majority vote over nrep copies in cp[]; returns disagreeing-bit count.
    task automatic vote(input int nrep, output logic [127:0] blk, output int flips);
        int s;
        flips = 0;
        for (int k = 0; k < 128; k++) begin
            s = 0;
            for (int c = 0; c < nrep; c++) s += int'(cp[c][k]);
            blk[k] = (s > nrep / 2);
            if (s != 0 && s != nrep) flips++;
        end
    endtask

    task automatic put1(input logic [127:0] d);
        bit ok = 0;
        int n  = 0;
        in_valid1 = 1'b1;
        data1     = d;
        while (!ok && n < 8) begin
            ok = in_ready1;
            @(posedge clk); #1;
            n++;
        end
        in_valid1 = 1'b0;
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL put1_timeout: in_ready never high within %0d cycles", n);
        end
    endtask

    task automatic put2(input logic [63:0] d);
        bit ok = 0;
        int n  = 0;
        in_valid2 = 1'b1;
        data2     = d;
        while (!ok && n < 8) begin
            ok = in_ready2;
            @(posedge clk); #1;
            n++;
        end
        in_valid2 = 1'b0;
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL put2_timeout: in_ready never high within %0d cycles", n);
        end
    endtask

    task automatic rd1(input logic [5:0] a, output logic [127:0] v);
        rd_en1 = 1'b1; rd_addr1 = a;
        @(posedge clk); #1;
        rd_en1 = 1'b0;
        v = blk_out1;
    endtask

    task automatic rd2(input logic [5:0] a, output logic [127:0] v);
        rd_en2 = 1'b1; rd_addr2 = a;
        @(posedge clk); #1;
        rd_en2 = 1'b0;
        v = blk_out2;
    endtask

    task automatic start1_pulse();
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        eflip1 = 0;
        n_checks++;
        if (in_ready1 !== 1'b1) begin
            n_fail++; $display("FAIL start1_in_ready: got %b want 1", in_ready1);
        end
    endtask

    // kind 0: block p = {16{p}}; 1: random data with sparse random flips;
    // 2/3: pattern data with bit 0 of block 3 flipped in the first 2/3 copies.
    task automatic stream1(input int kind);
        logic [127:0] base, blk;
        int f;
        for (int p = 0; p < 56; p++) begin
            base = (kind == 1) ? rand128() : {16{8'(p)}};
            for (int c = 0; c < 5; c++)
                fm[c] = (kind == 1 && $urandom_range(0, 2) == 0) ? sparse128() : '0;
            if (p == 3 && kind >= 2)
                for (int c = 0; c < ((kind == 2) ? 2 : 3); c++) fm[c][0] = 1'b1;
            for (int c = 0; c < 5; c++) cp[c] = base ^ fm[c];
            vote(5, blk, f);
            exp1[p] = blk;
            eflip1  = (eflip1 + f > 65535) ? 65535 : eflip1 + f;
            for (int c = 0; c < 5; c++) begin
                if (p == 55 && c == 4) begin
                    n_checks++;
                    if (done1 !== 1'b0) begin
                        n_fail++; $display("FAIL done1_early: got %b want 0", done1);
                    end
                end
                put1(cp[c]);
            end
        end
        n_checks++;
        if (done1 !== 1'b1 || in_ready1 !== 1'b0) begin
            n_fail++;
            $display("FAIL done1_after_last: done=%b in_ready=%b want done=1 in_ready=0", done1, in_ready1);
        end
    endtask

    task automatic check_all1(input string tag);
        logic [127:0] v;
        for (int p = 0; p < 56; p++) begin
            rd1(6'(p), v);
            n_checks++;
            if (v !== exp1[p]) begin
                n_fail++; $display("FAIL %s_blk%0d: got %h want %h", tag, p, v, exp1[p]);
            end
        end
`ifdef REP_FLIP_CNT_EN
        n_checks++;
        if (flip1 !== 16'(eflip1)) begin
            n_fail++; $display("FAIL %s_flip: got %0d want %0d", tag, flip1, eflip1);
        end
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start1 = 0; in_valid1 = 0; data1 = '0; rd_en1 = 0; rd_addr1 = '0;
        start2 = 0; in_valid2 = 0; data2 = '0; rd_en2 = 0; rd_addr2 = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready1 !== 1'b0 || done1 !== 1'b0 || blk_out1 !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: in_ready=%b done=%b blk_out=%h want 0 0 0", in_ready1, done1, blk_out1);
        end
`ifdef REP_FLIP_CNT_EN
        n_checks++;
        if (flip1 !== 16'd0) begin
            n_fail++; $display("FAIL reset_flip: got %0d want 0", flip1);
        end
`endif
        rst_n = 1'b1;
        // Chunks offered in IDLE must be ignored.
        in_valid1 = 1'b1; data1 = rand128();
        repeat (3) @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        n_checks++;
        if (in_ready1 !== 1'b0 || done1 !== 1'b0) begin
            n_fail++; $display("FAIL idle_ignore: in_ready=%b done=%b want 0 0", in_ready1, done1);
        end
    endtask

    task automatic test_clean_stream();
        logic [127:0] v;
        start1_pulse();
        stream1(0);
        rd1(6'd55, v);
        n_checks++;
        if (v !== {16{8'h37}}) begin
            n_fail++; $display("FAIL read_after_final: got %h want %h", v, {16{8'h37}});
        end
        // Chunks offered in DONE must be ignored.
        in_valid1 = 1'b1; data1 = '1;
        repeat (2) @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        rd1(6'd7, v);
        n_checks++;
        if (v !== {16{8'h07}}) begin
            n_fail++; $display("FAIL read_addr7: got %h want %h", v, {16{8'h07}});
        end
        rd_addr1 = 6'd9;
        @(posedge clk); #1;
        n_checks++;
        if (blk_out1 !== {16{8'h07}}) begin
            n_fail++; $display("FAIL read_hold: got %h want %h", blk_out1, {16{8'h07}});
        end
        rd1(6'd56, v);
        n_checks++;
        if (v !== '0) begin
            n_fail++; $display("FAIL read_addr56: got %h want 0", v);
        end
        rd1(6'd63, v);
        n_checks++;
        if (v !== '0) begin
            n_fail++; $display("FAIL read_addr63: got %h want 0", v);
        end
        check_all1("clean");
    endtask

    task automatic test_majority();
        logic [127:0] v;
        start1_pulse();
        stream1(2);
        rd1(6'd3, v);
        n_checks++;
        if (v !== {16{8'h03}}) begin
            n_fail++; $display("FAIL maj_two_flips: got %h want %h", v, {16{8'h03}});
        end
`ifdef REP_FLIP_CNT_EN
        n_checks++;
        if (flip1 !== 16'd1) begin
            n_fail++; $display("FAIL maj_two_flip_cnt: got %0d want 1", flip1);
        end
`endif
        start1_pulse();
        stream1(3);
        rd1(6'd3, v);
        n_checks++;
        if (v !== {{15{8'h03}}, 8'h02}) begin
            n_fail++; $display("FAIL maj_three_flips: got %h want %h", v, {{15{8'h03}}, 8'h02});
        end
`ifdef REP_FLIP_CNT_EN
        n_checks++;
        if (flip1 !== 16'd1) begin
            n_fail++; $display("FAIL maj_three_flip_cnt: got %0d want 1", flip1);
        end
`endif
        check_all1("maj");
    endtask

    task automatic test_random();
        start1_pulse();
        stream1(1);
        check_all1("random");
    endtask

    task automatic test_restart();
        start1_pulse();
        for (int i = 0; i < 100; i++) put1(rand128());
        start1_pulse();
        n_checks++;
        if (done1 !== 1'b0) begin
            n_fail++; $display("FAIL restart_done: got %b want 0", done1);
        end
        stream1(1);
        check_all1("restart");
    endtask

    task automatic test_start_with_valid();
        start1_pulse();
        for (int i = 0; i < 10; i++) put1(rand128());
        start1 = 1'b1; in_valid1 = 1'b1; data1 = rand128();
        @(posedge clk); #1;
        start1 = 1'b0; in_valid1 = 1'b0;
        eflip1 = 0;
        stream1(1);
        check_all1("start_valid");
    endtask

    task automatic test_reset_mid();
        logic [127:0] v;
        start1_pulse();
        for (int i = 0; i < 50; i++) put1(rand128());
        rd1(6'd40, v);
        n_checks++;
        if (v !== exp1[40]) begin
            n_fail++; $display("FAIL pre_reset_read: got %h want %h", v, exp1[40]);
        end
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (in_ready1 !== 1'b0 || done1 !== 1'b0 || blk_out1 !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: in_ready=%b done=%b blk_out=%h want 0 0 0", in_ready1, done1, blk_out1);
        end
`ifdef REP_FLIP_CNT_EN
        n_checks++;
        if (flip1 !== 16'd0) begin
            n_fail++; $display("FAIL mid_reset_flip: got %0d want 0", flip1);
        end
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        start1_pulse();
        stream1(0);
        check_all1("recover");
    endtask

    task automatic test_hqc128_gapped();
        logic [127:0] base, blk, v;
        int f;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        eflip2 = 0;
        for (int p = 0; p < 46; p++) begin
            base = rand128();
            for (int c = 0; c < 3; c++) begin
                fm[c] = ($urandom_range(0, 1) == 0) ? sparse128() : '0;
                cp[c] = base ^ fm[c];
            end
            vote(3, blk, f);
            exp2[p] = blk;
            eflip2 += f;
            for (int c = 0; c < 3; c++) begin
                put2(cp[c][63:0]);
                @(posedge clk); #1;
                if (p == 45 && c == 2) begin
                    n_checks++;
                    if (done2 !== 1'b0) begin
                        n_fail++; $display("FAIL done2_early: got %b want 0", done2);
                    end
                end
                put2(cp[c][127:64]);
                if (!(p == 45 && c == 2)) begin
                    @(posedge clk); #1;
                end
            end
        end
        n_checks++;
        if (done2 !== 1'b1 || in_ready2 !== 1'b0) begin
            n_fail++;
            $display("FAIL done2_after_276: done=%b in_ready=%b want 1 0", done2, in_ready2);
        end
        rd2(6'd45, v);
        rd2(6'd46, v);
        n_checks++;
        if (v !== '0) begin
            n_fail++; $display("FAIL hqc128_addr46: got %h want 0", v);
        end
        for (int p = 0; p < 46; p++) begin
            rd2(6'(p), v);
            n_checks++;
            if (v !== exp2[p]) begin
                n_fail++; $display("FAIL hqc128_blk%0d: got %h want %h", p, v, exp2[p]);
            end
        end
`ifdef REP_FLIP_CNT_EN
        n_checks++;
        if (flip2 !== 16'(eflip2)) begin
            n_fail++; $display("FAIL hqc128_flip: got %0d want %0d", flip2, eflip2);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_clean_stream();
        test_majority();
        test_random();
        test_restart();
        test_start_with_valid();
        test_reset_mid();
        test_hqc128_gapped();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rep_collapse_ingest.md
# rep_collapse_ingest

Decoder-side front end for the concatenated-code path. It accepts the received, repetition-expanded codeword as an in-order stream of IN_WIDTH_BITS chunks, in the same chunk and byte order the encoder wrapper emits. For each of the REP_COUNT copies of every 128-bit inner block it takes a per-bit majority vote and stores one hard-decision 128-bit block per outer symbol. The inner decoder then reads those blocks by address.

## Interface
- parameter_set, "hqc192": selects N1_BYTES/REP_COUNT ("hqc128" 46/3, "hqc192" 56/5, "hqc256" 90/5)
- IN_WIDTH_BITS, 128: chunk width; must be 32, 64 or 128 (divides 128)
- N1_BYTES, derived: number of physical inner blocks
- REP_COUNT, derived: copies per block (always odd)
- WPB, derived: 128/IN_WIDTH_BITS chunks per copy
- CNT_W, derived: clog2(REP_COUNT+1)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; (re)starts collection
- in_valid  in  1  chunk valid
- in_ready  out  1  high only in COLLECT
- data_in  in  IN_WIDTH_BITS  chunk; byte b at data_in[8b+:8]
- blk_rd_en  in  1  block read strobe
- blk_rd_addr  in  clog2(N1_BYTES)  physical block index
- blk_out  out  128  registered block read data
- done  out  1  all blocks collapsed; level until start or reset
- flip_cnt  out  16  disagreement count (only with REP_FLIP_CNT_EN)

## Operation
- States: IDLE (after reset), COLLECT, DONE.
- IDLE→COLLECT on start. In COLLECT or DONE, start clears the counters, word/copy/block indices, done and flip_cnt, then re-enters COLLECT. Block memory is not cleared.
- A chunk is accepted when in_valid && in_ready. Chunk j covers virtual-stream bits [j*IN_WIDTH_BITS +: IN_WIDTH_BITS].
- Indices: word w (0..WPB-1), copy c (0..REP_COUNT-1), block p (0..N1_BYTES-1). Each accept advances w; w wraps into c; c wraps into p.
- Per-bit counters: 128 × CNT_W bits. Accepted chunk bit i adds to counter[w*IN_WIDTH_BITS+i].
- Final chunk of block p (w=WPB-1, c=REP_COUNT-1), on the same edge:
  - mem[p][k] <= (count_k incl. current bit) > REP_COUNT/2
  - all counters clear
- After the final chunk of block N1_BYTES-1: state→DONE, done=1, in_ready=0.
- Total chunks accepted = N1_BYTES*REP_COUNT*WPB. Chunks presented in IDLE/DONE are ignored.
- Reads: blk_rd_en with addr<N1_BYTES loads mem[addr] into blk_out. addr≥N1_BYTES loads 0. Reads are legal in any state; data is meaningful only when done=1.
- start together with in_valid: start wins and the chunk is dropped.

## Timing
- Reset values: in_ready=0, done=0, blk_out=0, flip_cnt=0, state IDLE, counters 0.
- in_ready rises the cycle after start. Throughput is one chunk per cycle, and in_valid gaps are allowed.
- done rises the cycle after the last accepted chunk.
- Read latency 1: blk_out updates on the edge that samples blk_rd_en and holds otherwise. A read of block p issued the cycle after p's final chunk returns the new data.
- Reset mid-COLLECT aborts immediately. Counters, indices and outputs return to reset values; memory contents are undefined.

## Configuration
- REP_FLIP_CNT_EN defined:
  - flip_cnt port exists.
  - At each block finalisation it adds the number of bits whose count is neither 0 nor REP_COUNT; it saturates at 16'hFFFF and clears on start.
- Undefined: port and logic are absent, and the remaining behaviour is identical.

## Test plan
- hqc192, IN=128: block p = {16{p[7:0]}} sent 5× for all 56 blocks (280 chunks) -> done one cycle after chunk 280; reading addr 7 gives {16{8'h07}}.
- hqc192: block 3 bit 0 flipped in copies 0 and 1 -> mem[3] correct; flip_cnt=1 (macro on). Flipped in copies 0,1,2 -> mem[3][0] inverted; flip_cnt=1.
- hqc128, IN=64: 276 chunks with in_valid toggling every other cycle -> done after exactly 276 accepts; addr 46 returns 0.
- start pulsed after 100 chunks, then a full clean stream -> correct blocks, done once, flip_cnt reflects only the second stream.
- rst_n low for 1 cycle mid-COLLECT -> in_ready=0, done=0, blk_out=0 immediately; start plus a full stream recovers.
- start and in_valid in the same cycle in COLLECT -> chunk dropped; the next 280 accepted chunks complete collection.
